pipe_reg_file: RTL and testbench
================================

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- REG_FILE_ADDR_WIDTH, 5, register index width; depth = 2**REG_FILE_ADDR_WIDTH.
- DATA_WIDTH, 32, register width; SHALL be a multiple of 8.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- WE3, in, 1, write-back enable.
- WBE3, in, DATA_WIDTH/8, byte enables for write-back.
- AD3, in, REG_FILE_ADDR_WIDTH, write-back register index.
- WD3, in, DATA_WIDTH, write-back data.
- AD1, in, REG_FILE_ADDR_WIDTH, read port 1 index.
- AD2, in, REG_FILE_ADDR_WIDTH, read port 2 index.
- use1, in, 1, AD1 is a live source operand this cycle.
- use2, in, 1, AD2 is a live source operand this cycle.
- issue_en, in, 1, an instruction writing issue_rd issues this cycle.
- issue_rd, in, REG_FILE_ADDR_WIDTH, destination of the issuing instruction.
- dbg_addr, in, REG_FILE_ADDR_WIDTH, debug read index.
- RD1, out, DATA_WIDTH signed, read data port 1.
- RD2, out, DATA_WIDTH signed, read data port 2.
- dbg_data, out, DATA_WIDTH, debug read data (never forwarded).
- hazard, out, 1, a live source is pending write-back.
- busy_count, out, REG_FILE_ADDR_WIDTH+1, number of registers with busy set.

Function
REQ-003 Storage SHALL be 2**REG_FILE_ADDR_WIDTH registers of DATA_WIDTH bits, written only on rising clk.
REQ-004 Register 0 SHALL read as zero on every port; writes and issues to index 0 SHALL be ignored.
REQ-005 When WE3=1 and AD3!=0, each byte lane i with WBE3[i]=1 SHALL take WD3 lane i at the edge; other lanes SHALL hold.
REQ-006 RD1, RD2 and dbg_data SHALL be combinational reads of stored contents (zero latency after the write edge).
REQ-007 With BYPASS=1, RD1 SHALL present the merged value when WE3=1, AD3!=0 and AD3==AD1; merged = WD3 on enabled lanes, stored data elsewhere. RD2 SHALL behave likewise for AD2.
REQ-008 With BYPASS=0, a write SHALL become visible on RD1/RD2 only after the write edge.
REQ-009 A busy bit per register SHALL exist; busy[0] SHALL be constant 0.
REQ-010 issue_en=1 with issue_rd!=0 SHALL set busy[issue_rd] at the edge.
REQ-011 WE3=1 with AD3!=0 SHALL clear busy[AD3] at the edge, whether or not any WBE3 bit is set.
REQ-012 Simultaneous set and clear of the same index SHALL leave busy set (new producer wins).
REQ-013 issue_en to an already-busy index SHALL leave it busy; the block tracks one pending producer per register.
REQ-014 hazard SHALL be combinational: (use1 & busy[AD1] & !fwd1) | (use2 & busy[AD2] & !fwd2).
REQ-015 fwd1 SHALL be 1 only when BYPASS=1, WE3=1, AD3==AD1, AD3!=0, and WBE3 is all ones; fwd2 SHALL be defined likewise for AD2.
REQ-016 busy_count SHALL be registered and equal the population count of busy after each edge; it SHALL saturate at neither end, since its range covers all registers.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, clear all registers to 0, all busy bits to 0 and busy_count to 0.
REQ-018 While rst_n=0, RD1, RD2 and dbg_data SHALL read 0 except bypass values per REQ-007; hazard SHALL be 0; writes and issues SHALL be ignored.
REQ-019 Deassertion of rst_n SHALL take effect at the next rising clk; reset mid-operation SHALL discard all pending busy state.

Verification
REQ-020 Bench SHALL cover:
- Reset: after reset, RD1/RD2/dbg_data all read 0 for every index and busy_count reads 0.
- x0: WE3=1, AD3=0, WD3=0xDEADBEEF, then AD1=0 -> RD1=0, busy_count unchanged.
- Byte write with BYPASS=1: reg 5=0x11223344, then WE3=1, AD3=5, WBE3=0b0010, WD3=0xAABBCCDD with AD1=5 in that cycle -> RD1=0x1122CC44 same cycle, hazard follows REQ-015 (partial write is not forwarded), stored value 0x1122CC44 after the edge.
- Scoreboard: issue_en=1, issue_rd=7, next cycle use1=1, AD1=7 -> hazard=1, busy_count=1; full write-back to 7 with BYPASS=1 -> hazard=0 same cycle, busy_count=0 after the edge.
- Collision: issue_en=1, issue_rd=9 and WE3=1, AD3=9 in one cycle, with busy[9] previously set -> busy[9] remains 1, busy_count unchanged.
- Async reset mid-run: assert rst_n=0 between clk edges with 3 busy registers -> busy_count=0 and hazard=0 immediately, all registers read 0.

Source files
------------

// File: rtl/pipe_reg_file.sv
// Register file with byte-enabled write-back, optional same-cycle forwarding,
// and a per-register busy scoreboard that flags read-after-write hazards.
module pipe_reg_file #(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int BYPASS              = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                WE3,
  input  logic [DATA_WIDTH/8-1:0]             WBE3,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      AD3,
  input  logic [DATA_WIDTH-1:0]               WD3,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      AD1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      AD2,
  input  logic                                use1,
  input  logic                                use2,
  input  logic                                issue_en,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      issue_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      dbg_addr,
  output logic signed [DATA_WIDTH-1:0]        RD1,
  output logic signed [DATA_WIDTH-1:0]        RD2,
  output logic [DATA_WIDTH-1:0]               dbg_data,
  output logic                                hazard,
  output logic [REG_FILE_ADDR_WIDTH:0]        busy_count
);

  localparam int DEPTH  = 1 << REG_FILE_ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [REG_FILE_ADDR_WIDTH-1:0] ZERO_IDX = '0;

  logic [DATA_WIDTH-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [DATA_WIDTH-1:0]        wmask;
  logic [REG_FILE_ADDR_WIDTH:0] pop_nxt;
  logic                         wr_en;
  logic                         iss_en;
  logic                         hit1;
  logic                         hit2;
  logic                         fwd1;
  logic                         fwd2;

  assign wr_en  = WE3 && (AD3 != ZERO_IDX);
  assign iss_en = issue_en && (issue_rd != ZERO_IDX);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wmask[i*8 +: 8] = {8{WBE3[i]}};
    end
  end

  // Register 0 is never written, so plain indexed reads already return zero for it.
  assign hit1 = (BYPASS != 0) && wr_en && (AD3 == AD1);
  assign hit2 = (BYPASS != 0) && wr_en && (AD3 == AD2);
  assign fwd1 = hit1 && (&WBE3);
  assign fwd2 = hit2 && (&WBE3);

  assign RD1      = hit1 ? ((regs[AD1] & ~wmask) | (WD3 & wmask)) : regs[AD1];
  assign RD2      = hit2 ? ((regs[AD2] & ~wmask) | (WD3 & wmask)) : regs[AD2];
  assign dbg_data = regs[dbg_addr];

  // A partial write-back is not forwarded, so the consumer must still stall on it.
  assign hazard = (use1 && busy[AD1] && !fwd1) || (use2 && busy[AD2] && !fwd2);

  // Clear before set so a new producer issuing on the write-back cycle keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[AD3]      = 1'b0;
    if (iss_en) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop_nxt = pop_nxt + {{REG_FILE_ADDR_WIDTH{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[AD3] <= (regs[AD3] & ~wmask) | (WD3 & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= pop_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: one forwarding instance and one without
// forwarding share the same stimulus.
module tb_pipe_reg_file;

  logic        clk;
  logic        rst_n;
  logic        WE3;
  logic [3:0]  WBE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;
  logic [4:0]  AD1;
  logic [4:0]  AD2;
  logic        use1;
  logic        use2;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  dbg_addr;

  logic signed [31:0] rd1, rd2, rd1_b, rd2_b;
  logic [31:0]        dbg, dbg_b;
  logic               hazard, hazard_b;
  logic [5:0]         busy_count, busy_count_b;

  int checks = 0;
  int errors = 0;

  pipe_reg_file #(.REG_FILE_ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .WBE3(WBE3), .AD3(AD3), .WD3(WD3),
    .AD1(AD1), .AD2(AD2), .use1(use1), .use2(use2), .issue_en(issue_en),
    .issue_rd(issue_rd), .dbg_addr(dbg_addr), .RD1(rd1), .RD2(rd2),
    .dbg_data(dbg), .hazard(hazard), .busy_count(busy_count)
  );

  pipe_reg_file #(.REG_FILE_ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .WBE3(WBE3), .AD3(AD3), .WD3(WD3),
    .AD1(AD1), .AD2(AD2), .use1(use1), .use2(use2), .issue_en(issue_en),
    .issue_rd(issue_rd), .dbg_addr(dbg_addr), .RD1(rd1_b), .RD2(rd2_b),
    .dbg_data(dbg_b), .hazard(hazard_b), .busy_count(busy_count_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE3 = 0; WBE3 = 4'h0; AD3 = 0; WD3 = 0; AD1 = 0; AD2 = 0;
    use1 = 0; use2 = 0; issue_en = 0; issue_rd = 0; dbg_addr = 0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    WE3 = 1; AD3 = a; WBE3 = be; WD3 = d;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    issue_en = 1; issue_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count: got %0d exp 0", busy_count); end
    for (int i = 0; i < 32; i++) begin
      AD1 = 5'(i); AD2 = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      checks++; if (rd1 !== 32'sd0 || rd2 !== 32'sd0 || dbg !== 32'd0)
        begin errors++; $display("FAIL reset_read idx %0d: got rd1=%h rd2=%h dbg=%h exp 0", i, rd1, rd2, dbg); end
    end
    // Bypass still presents the merged value while reset is held; writes/issues are dropped.
    drive_write(5'd3, 4'hF, 32'h12345678); drive_issue(5'd3);
    AD1 = 5'd3; use1 = 1; dbg_addr = 5'd3;
    #1;
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL reset_bypass: got %h exp 12345678", rd1); end
    checks++; if (rd1_b !== 32'sd0) begin errors++; $display("FAIL reset_nobypass: got %h exp 0", rd1_b); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b exp 0", hazard); end
    tick();
    idle_inputs(); AD1 = 5'd3; dbg_addr = 5'd3;
    #1;
    checks++; if (dbg !== 32'd0 || busy_count !== 6'd0)
      begin errors++; $display("FAIL reset_write_ignored: got dbg=%h busy_count=%0d exp 0/0", dbg, busy_count); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_x0();
    idle_inputs();
    drive_write(5'd0, 4'hF, 32'hDEADBEEF); drive_issue(5'd0);
    AD1 = 5'd0; AD2 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'sd0 || rd2 !== 32'sd0) begin errors++; $display("FAIL x0_same_cycle: got rd1=%h rd2=%h exp 0", rd1, rd2); end
    tick();
    idle_inputs();
    #1;
    checks++; if (rd1 !== 32'sd0 || dbg !== 32'd0) begin errors++; $display("FAIL x0_after: got rd1=%h dbg=%h exp 0", rd1, dbg); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL x0_busy_count: got %0d exp 0", busy_count); end
  endtask

  task automatic test_byte_write();
    idle_inputs();
    drive_write(5'd5, 4'hF, 32'h11223344);
    tick();
    idle_inputs(); drive_issue(5'd5);
    tick();
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL byte_busy_set: got %0d exp 1", busy_count); end
    drive_write(5'd5, 4'b0010, 32'hAABBCCDD);
    AD1 = 5'd5; AD2 = 5'd5; use1 = 1; dbg_addr = 5'd5;
    #1;
    checks++; if (rd1 !== 32'h1122CC44) begin errors++; $display("FAIL byte_fwd_rd1: got %h exp 1122cc44", rd1); end
    checks++; if (rd2 !== 32'h1122CC44) begin errors++; $display("FAIL byte_fwd_rd2: got %h exp 1122cc44", rd2); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL byte_partial_hazard: got %b exp 1", hazard); end
    checks++; if (rd1_b !== 32'h11223344) begin errors++; $display("FAIL byte_nobyp_old: got %h exp 11223344", rd1_b); end
    checks++; if (dbg !== 32'h11223344) begin errors++; $display("FAIL byte_dbg_not_fwd: got %h exp 11223344", dbg); end
    tick();
    idle_inputs(); AD1 = 5'd5; use1 = 1; dbg_addr = 5'd5;
    #1;
    checks++; if (rd1 !== 32'h1122CC44 || dbg !== 32'h1122CC44)
      begin errors++; $display("FAIL byte_stored: got rd1=%h dbg=%h exp 1122cc44", rd1, dbg); end
    checks++; if (rd1_b !== 32'h1122CC44) begin errors++; $display("FAIL byte_nobyp_after: got %h exp 1122cc44", rd1_b); end
    checks++; if (busy_count !== 6'd0 || hazard !== 1'b0)
      begin errors++; $display("FAIL byte_busy_clear: got count=%0d hazard=%b exp 0/0", busy_count, hazard); end
  endtask

  task automatic test_scoreboard();
    idle_inputs(); drive_issue(5'd7);
    tick();
    idle_inputs(); use1 = 1; AD1 = 5'd7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_set: got %b exp 1", hazard); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL sb_busy_count: got %0d exp 1", busy_count); end
    use1 = 0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_use_gate: got %b exp 0", hazard); end
    use1 = 1;
    drive_write(5'd7, 4'hF, 32'hCAFEF00D);
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_fwd_clears_hazard: got %b exp 0", hazard); end
    checks++; if (rd1 !== 32'hCAFEF00D) begin errors++; $display("FAIL sb_fwd_data: got %h exp cafef00d", rd1); end
    checks++; if (hazard_b !== 1'b1) begin errors++; $display("FAIL sb_nobyp_hazard: got %b exp 1", hazard_b); end
    tick();
    idle_inputs(); use1 = 1; AD1 = 5'd7;
    #1;
    checks++; if (busy_count !== 6'd0 || hazard !== 1'b0)
      begin errors++; $display("FAIL sb_after_wb: got count=%0d hazard=%b exp 0/0", busy_count, hazard); end
    // Same flow on read port 2.
    idle_inputs(); drive_issue(5'd8);
    tick();
    idle_inputs(); use2 = 1; AD2 = 5'd8; AD1 = 5'd8;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_port2_hazard: got %b exp 1", hazard); end
    drive_write(5'd8, 4'hF, 32'h80000001);
    #1;
    checks++; if (hazard !== 1'b0 || rd2 !== 32'h80000001)
      begin errors++; $display("FAIL sb_port2_fwd: got hazard=%b rd2=%h exp 0/80000001", hazard, rd2); end
    tick();
    idle_inputs();
  endtask

  task automatic test_collision();
    idle_inputs(); drive_issue(5'd9);
    tick();
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL col_pre: got %0d exp 1", busy_count); end
    drive_issue(5'd9); drive_write(5'd9, 4'hF, 32'h00000099);
    tick();
    idle_inputs(); use1 = 1; AD1 = 5'd9;
    #1;
    checks++; if (busy_count !== 6'd1 || hazard !== 1'b1)
      begin errors++; $display("FAIL col_busy_kept: got count=%0d hazard=%b exp 1/1", busy_count, hazard); end
    checks++; if (rd1 !== 32'h00000099) begin errors++; $display("FAIL col_data: got %h exp 00000099", rd1); end
    drive_issue(5'd9);
    tick();
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL col_reissue: got %0d exp 1", busy_count); end
    drive_write(5'd9, 4'h0, 32'hFFFFFFFF);
    tick();
    idle_inputs(); dbg_addr = 5'd9;
    #1;
    checks++; if (busy_count !== 6'd0 || dbg !== 32'h00000099)
      begin errors++; $display("FAIL col_no_lane_clear: got count=%0d dbg=%h exp 0/00000099", busy_count, dbg); end
  endtask

  task automatic test_async_reset();
    idle_inputs(); drive_issue(5'd10);
    tick();
    drive_issue(5'd11);
    tick();
    drive_issue(5'd12);
    tick();
    idle_inputs(); use1 = 1; AD1 = 5'd10; use2 = 1; AD2 = 5'd12;
    #1;
    checks++; if (busy_count !== 6'd3 || hazard !== 1'b1)
      begin errors++; $display("FAIL ar_pre: got count=%0d hazard=%b exp 3/1", busy_count, hazard); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (busy_count !== 6'd0 || hazard !== 1'b0)
      begin errors++; $display("FAIL ar_immediate: got count=%0d hazard=%b exp 0/0", busy_count, hazard); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      checks++; if (dbg !== 32'd0) begin errors++; $display("FAIL ar_regs idx %0d: got %h exp 0", i, dbg); end
    end
    tick();
    rst_n = 1;
    tick();
    idle_inputs(); drive_write(5'd4, 4'b1001, 32'hA1B2C3D4);
    tick();
    idle_inputs(); dbg_addr = 5'd4;
    #1;
    checks++; if (dbg !== 32'hA10000D4 || busy_count !== 6'd0)
      begin errors++; $display("FAIL ar_after_release: got dbg=%h count=%0d exp a10000d4/0", dbg, busy_count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_x0();
    test_byte_write();
    test_scoreboard();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
